// File: rtl/sync_filter_bank.sv
// sync_filter_bank: per-channel STAGES-flop synchronizer, persistence glitch filter, optional edge pulses (macro SYNC_FILTER_EDGE_EN).
// Latency: STAGES-1+FILTER_LEN enabled edges from capture in sync[0] to data_out; all outputs registered. No backpressure; en=0 freezes all state.
module sync_filter_bank #(
    parameter int               WIDTH      = 4,
    parameter int               STAGES     = 2,
    parameter int               FILTER_LEN = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    localparam int            CW       = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]             r_data_out;
    logic [CW-1:0]                r_cnt [WIDTH];
    logic [WIDTH-1:0]             w_sync_out;

    // Only the last stage is ever read; sync[0] is the metastability catcher.
    assign w_sync_out = r_sync[STAGES-1];
    assign data_out   = r_data_out;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else if (en) begin
            r_sync <= {r_sync[STAGES-2:0], data_in};
        end
    end

    // A disagreeing level must persist FILTER_LEN enabled samples; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_data_out <= RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_sync_out[i] == r_data_out[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_data_out[i] <= w_sync_out[i];
                    r_cnt[i]      <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef SYNC_FILTER_EDGE_EN
    logic [WIDTH-1:0] w_upd;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    // w_upd marks the edge on which data_out takes sync_out, so the pulse lands with the new level.
    always_comb begin
        w_upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_upd[i] = en && (w_sync_out[i] != r_data_out[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_upd & w_sync_out;
            r_fall <= w_upd & ~w_sync_out;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = {WIDTH{1'b0}};
    assign fall = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_sync_filter_bank.sv
// Self-checking bench for sync_filter_bank: directed scenarios plus random traffic against a sample-history model.
module tb_sync_filter_bank;
    localparam int               WIDTH      = 4;
    localparam int               STAGES     = 2;
    localparam int               FILTER_LEN = 4;
    localparam logic [WIDTH-1:0] RV         = '0;
    localparam int               HL         = STAGES + FILTER_LEN;
`ifdef SYNC_FILTER_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstb;
    logic             en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    int nvec = 0;
    int nerr = 0;

    // Reference: history of enabled samples, newest first. hist[0] is the value just captured.
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] m_out, m_rise, m_fall;

    sync_filter_bank #(
        .WIDTH(WIDTH), .STAGES(STAGES), .FILTER_LEN(FILTER_LEN), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .rstb(rstb), .en(en), .data_in(data_in),
        .data_out(data_out), .rise(rise), .fall(fall)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hist = {};
        for (int j = 0; j < HL; j++) hist.push_back(RV);
        m_out  = RV;
        m_rise = '0;
        m_fall = '0;
    endtask

    // Drive one clock of stimulus and advance the model; outputs are sampled 1 time unit after the edge.
    task automatic tick(input logic r, input logic e, input logic [WIDTH-1:0] d);
        logic flip;
        rstb    = r;
        en      = e;
        data_in = d;
        @(posedge clk);
        if (!r) begin
            model_reset();
        end else if (!e) begin
            m_rise = '0;
            m_fall = '0;
        end else begin
            hist.push_front(d);
            void'(hist.pop_back());
            for (int b = 0; b < WIDTH; b++) begin
                // Filter at this edge sees samples captured STAGES..HL-1 enabled edges ago.
                flip = 1'b1;
                for (int j = STAGES; j < HL; j++)
                    if (hist[j][b] == m_out[b]) flip = 1'b0;
                m_rise[b] = EDGE && flip && !m_out[b];
                m_fall[b] = EDGE && flip && m_out[b];
                m_out[b]  = m_out[b] ^ flip;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] exp_o, exp_r;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 4'hF);
            nvec++;
            if (data_out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
                nerr++;
                $display("FAIL reset_hold: out=%h rise=%h fall=%h, want 0/0/0", data_out, rise, fall);
            end
        end
        for (int n = 1; n <= 8; n++) begin
            tick(1'b1, 1'b1, 4'hF);
            exp_o = (n >= 6) ? 4'hF : 4'h0;
            exp_r = (EDGE && n == 6) ? 4'hF : 4'h0;
            nvec++;
            if (data_out !== exp_o || rise !== exp_r || fall !== 4'h0) begin
                nerr++;
                $display("FAIL reset_exit n=%0d: out=%h rise=%h fall=%h, want %h/%h/0", n, data_out, rise, fall, exp_o, exp_r);
            end
        end
    endtask

    task automatic test_step();
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 4'h0);
        for (int n = 1; n <= 8; n++) begin
            tick(1'b1, 1'b1, 4'h1);
            nvec++;
            if (data_out[0] !== (n >= 6) || rise[0] !== (EDGE && n == 6) || fall !== 4'h0
                || data_out !== m_out || rise !== m_rise) begin
                nerr++;
                $display("FAIL step_rise n=%0d: out=%h rise=%h fall=%h, want %h/%h/%h", n, data_out, rise, fall, m_out, m_rise, m_fall);
            end
        end
        for (int n = 1; n <= 8; n++) begin
            tick(1'b1, 1'b1, 4'h0);
            nvec++;
            if (data_out[0] !== (n < 6) || fall[0] !== (EDGE && n == 6) || rise !== 4'h0
                || data_out !== m_out || fall !== m_fall) begin
                nerr++;
                $display("FAIL step_fall n=%0d: out=%h rise=%h fall=%h, want %h/%h/%h", n, data_out, rise, fall, m_out, m_rise, m_fall);
            end
        end
    endtask

    task automatic test_glitch();
        int nrise = 0;
        bit saw_hi = 1'b0;
        for (int n = 0; n < 13; n++) begin
            tick(1'b1, 1'b1, (n < 3) ? 4'h2 : 4'h0);
            nvec++;
            if (data_out[1] !== 1'b0 || rise[1] !== 1'b0 || data_out !== m_out) begin
                nerr++;
                $display("FAIL glitch_reject n=%0d: out=%h rise=%h, want out=%h rise[1]=0", n, data_out, rise, m_out);
            end
        end
        for (int n = 0; n < 14; n++) begin
            tick(1'b1, 1'b1, (n < 4) ? 4'h2 : 4'h0);
            if (data_out[1]) saw_hi = 1'b1;
            if (rise[1]) nrise++;
            nvec++;
            if (data_out !== m_out || rise !== m_rise || fall !== m_fall) begin
                nerr++;
                $display("FAIL glitch_model n=%0d: out=%h rise=%h fall=%h, want %h/%h/%h", n, data_out, rise, fall, m_out, m_rise, m_fall);
            end
        end
        nvec++;
        if (saw_hi !== 1'b1 || nrise !== (EDGE ? 1 : 0)) begin
            nerr++;
            $display("FAIL glitch_accept: saw_hi=%0d rises=%0d, want 1/%0d", saw_hi, nrise, EDGE ? 1 : 0);
        end
    endtask

    task automatic test_enable();
        int ne = 0;
        logic e;
        logic [WIDTH-1:0] prev;
        for (int c = 1; c <= 16; c++) begin
            e    = c[0];
            prev = data_out;
            tick(1'b1, e, 4'h4);
            if (e) ne++;
            nvec++;
            if (data_out[2] !== (ne >= 6) || rise[2] !== (EDGE && e && ne == 6)
                || (!e && (data_out !== prev || rise !== 4'h0 || fall !== 4'h0))
                || data_out !== m_out || rise !== m_rise) begin
                nerr++;
                $display("FAIL enable c=%0d ne=%0d: out=%h rise=%h fall=%h, want %h/%h/%h", c, ne, data_out, rise, fall, m_out, m_rise, m_fall);
            end
        end
        for (int n = 0; n < 10; n++) begin
            tick(1'b1, 1'b1, 4'h0);
            nvec++;
            if (data_out !== m_out || rise !== m_rise || fall !== m_fall) begin
                nerr++;
                $display("FAIL enable_settle n=%0d: out=%h rise=%h fall=%h, want %h/%h/%h", n, data_out, rise, fall, m_out, m_rise, m_fall);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 4; n++) tick(1'b1, 1'b1, 4'h8);
        tick(1'b0, 1'b1, 4'h8);
        nvec++;
        if (data_out !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
            nerr++;
            $display("FAIL reset_mid: out=%h rise=%h fall=%h, want 0/0/0", data_out, rise, fall);
        end
        for (int n = 1; n <= 8; n++) begin
            tick(1'b1, 1'b1, 4'h8);
            nvec++;
            if (data_out[3] !== (n >= 6) || rise[3] !== (EDGE && n == 6) || data_out !== m_out || rise !== m_rise) begin
                nerr++;
                $display("FAIL reset_mid_exit n=%0d: out=%h rise=%h, want %h/%h", n, data_out, rise, m_out, m_rise);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d = '0;
        logic r, e;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < WIDTH; b++)
                if ($urandom_range(0, 5) == 0) d[b] = ~d[b];
            r = ($urandom_range(0, 149) != 0);
            e = ($urandom_range(0, 3) != 0);
            tick(r, e, d);
            nvec++;
            if (data_out !== m_out || rise !== m_rise || fall !== m_fall || (rise & fall) !== 4'h0) begin
                nerr++;
                $display("FAIL random n=%0d: out=%h rise=%h fall=%h, want %h/%h/%h", n, data_out, rise, fall, m_out, m_rise, m_fall);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_step();
        test_glitch();
        test_enable();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sync_filter_bank.md
# sync_filter_bank

Multi-channel, parametrised input conditioner for asynchronous inputs. Each channel has a configurable-depth synchronizer chain followed by a glitch filter, and can optionally generate single-cycle edge pulses. It sits between the chip's asynchronous pins (buttons, external strobes, handshake lines) and the synchronous logic in the `clk` domain. The clock enable lets the whole bank run at a divided sample rate.

## Interface

Parameters:
- `WIDTH`, default 4: number of independent channels (≥1).
- `STAGES`, default 2: synchronizer flops per channel (≥2).
- `FILTER_LEN`, default 4: consecutive enabled samples a new level must persist before it is accepted (≥1).
- `RESET_VAL`, default `{WIDTH{1'b0}}`: reset level of the filtered outputs and all sync flops.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rstb`, input, 1: reset, synchronous, active-low.
- `en`, input, 1: sample enable; all state advances only when high.
- `data_in`, input, WIDTH: asynchronous channel inputs.
- `data_out`, output, WIDTH: synchronized, filtered levels.
- `rise`, output, WIDTH: one-cycle pulse when `data_out[i]` goes 0→1.
- `fall`, output, WIDTH: one-cycle pulse when `data_out[i]` goes 1→0.

## Operation

- Channels are fully independent and share only `clk`, `rstb` and `en`.
- Sync chain: per channel, a shift register of STAGES flops. `sync[0]` takes `data_in[i]`, and `sync_out` is `sync[STAGES-1]`. It shifts only on edges where `en`=1.
- Filter: per channel, a counter of width `$clog2(FILTER_LEN+1)` and a `data_out` register. On each enabled edge:
  - If `sync_out == data_out[i]`, cnt ← 0.
  - Else if `cnt == FILTER_LEN-1`, `data_out[i] ← sync_out` and cnt ← 0.
  - Else cnt ← cnt+1.
- Any sample that agrees with `data_out` clears the count. A disagreeing run shorter than FILTER_LEN samples is rejected entirely.
- The counter never exceeds FILTER_LEN-1 (no wrap).
- Edge pulses are registered:
  - `rise[i]`/`fall[i]` are 1 in exactly the cycle in which `data_out[i]` shows its new value, and 0 otherwise.
  - They are never both high on the same channel.
- When `en`=0: sync chain, counters and `data_out` hold their values, and `rise`/`fall` are forced 0 on that edge. A pulse is therefore at most one clk cycle wide regardless of `en`.
- Reset: while `rstb`=0 at a rising clk edge, all sync flops and `data_out` ← RESET_VAL, all counters ← 0, and `rise`/`fall` ← 0. `rstb` takes priority over `en`.
- Reset mid-count discards the partial count. A reset with `data_in` ≠ RESET_VAL produces no pulse at reset exit; a pulse comes only after the full latency.

## Timing

- Latency: a level change first captured by `sync[0]` on enabled edge E appears on `data_out` at enabled edge E+STAGES-1+FILTER_LEN. For the defaults, that is 6 enabled edges including E.
- With `en` duty-cycled, latency is counted in enabled edges only.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Minimum accepted pulse width: FILTER_LEN consecutive enabled samples at `sync_out`.
- Only `sync[0]` may go metastable. No logic reads `sync[0]` or any other stage except the last.

## Configuration

- Macro: `SYNC_FILTER_EDGE_EN`.
- Defined: the `rise`/`fall` pulse registers and logic are built as described above.
- Undefined: `rise` and `fall` are tied to `{WIDTH{1'b0}}` and no pulse registers exist. `data_out` behaviour and latency are unchanged.

## Test plan

All scenarios use defaults WIDTH=4, STAGES=2, FILTER_LEN=4, RESET_VAL=0, with the macro defined unless stated.

- Reset: hold `rstb`=0 for 3 edges with `data_in`=4'hF and `en`=1, then release. Required: `data_out`=0, `rise`=`fall`=0 during reset. After release, `data_out`=4'hF on the 6th enabled edge and `rise`=4'hF for exactly that cycle.
- Step and pulses: raise `data_in[0]` 0→1 before edge E and hold. Required: `data_out[0]`=1 at E+5 and `rise[0]` high for that single cycle. Drop it later: `fall[0]` pulses once, 6 edges after capture.
- Glitch rejection: `data_in[1]` high for 3 enabled cycles, then low. Required: `data_out[1]` stays 0 and `rise[1]` never asserts. A 4-cycle high is accepted.
- Enable gating: `en` high every other clk, and `data_in[2]` steps 0→1. Required: the update happens on the 6th enabled edge (~11 clks). `rise[2]` is 1 clk wide, and all state holds on `en`=0 edges.
- Reset mid-count: `data_in[3]` goes high, and `rstb` is pulsed low when cnt=2. Required: `data_out[3]`=0 and no pulse; after release, full 6-enabled-edge latency.
- Macro undefined: repeat the step scenario. Required: `rise`=`fall`=0 throughout, with identical `data_out` timing.
